// File: rtl/simon_input_checker.sv
// Simon user-side checker: debounces 8 buttons, decodes single-key presses and
// compares them against the 8-step pattern, flagging correct/wrong entry.
module simon_input_checker #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ERR_HOLD        = 32,
    parameter logic [23:0] PATTERN         = 24'o43627051
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn,
    input  logic       clear,
    output logic       Correct,
    output logic       wrong,
    output logic       key_ack,
    output logic [3:0] progress
);

    localparam int unsigned NKEYS   = 8;
    localparam int unsigned CW      = 8;
    localparam int unsigned PW      = 4;
    localparam int unsigned SEQ_LEN = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RELEASE,
        S_ERROR,
        S_DONE
    } state_e;

    logic [NKEYS-1:0] sync1_q, sync2_q, prev_q;
    logic [NKEYS-1:0] stable_q, stable_d;
    logic [CW-1:0]    db_cnt_q, db_cnt_d;
    logic [CW-1:0]    err_cnt_q, err_cnt_d;
    logic [PW-1:0]    progress_q, progress_d;
    logic             key_ack_q, key_ack_d;
    logic             wrong_q, wrong_d;
    logic             correct_q, correct_d;
    state_e           state_q, state_d;

    logic             press_c;
    logic             match_c;
    logic [2:0]       exp_key_c;

    // Debounce: counter restarts on any change of the synchronized vector
    always_comb begin
        db_cnt_d = db_cnt_q;
        if (sync2_q != prev_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != {CW{1'b1}}) begin
            db_cnt_d = db_cnt_q + CW'(1);
        end
        stable_d = (db_cnt_q == CW'(DEBOUNCE_CYCLES)) ? prev_q : stable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            db_cnt_q <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            db_cnt_q <= db_cnt_d;
            stable_q <= stable_d;
        end
    end

    // A press is the stable vector leaving all-zero; a one-hot match is a correct key
    always_comb begin
        exp_key_c = PATTERN[3 * progress_q[2:0] +: 3];
        press_c   = (stable_q == '0) && (stable_d != '0);
        match_c   = (stable_d == (NKEYS'(1) << exp_key_c));
    end

    always_comb begin
        state_d    = state_q;
        progress_d = progress_q;
        err_cnt_d  = err_cnt_q;
        key_ack_d  = 1'b0;
        if (clear) begin
            state_d    = S_IDLE;
            progress_d = '0;
            err_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (press_c) begin
                        if (match_c) begin
                            key_ack_d  = 1'b1;
                            progress_d = progress_q + PW'(1);
                            state_d    = (progress_q == PW'(SEQ_LEN - 1)) ? S_DONE : S_RELEASE;
                        end else begin
                            progress_d = '0;
                            err_cnt_d  = CW'(ERR_HOLD - 1);
                            state_d    = S_ERROR;
                        end
                    end
                end
                S_RELEASE: begin
                    if (stable_q == '0) begin
                        state_d = S_IDLE;
                    end
                end
                S_ERROR: begin
                    progress_d = '0;
                    if (err_cnt_q == '0) begin
                        state_d = S_RELEASE;
                    end else begin
                        err_cnt_d = err_cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    progress_d = PW'(SEQ_LEN);
                end
                default: begin
                    state_d    = S_IDLE;
                    progress_d = '0;
                end
            endcase
        end
        wrong_d   = (state_d == S_ERROR);
        correct_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            progress_q <= '0;
            err_cnt_q  <= '0;
            key_ack_q  <= 1'b0;
            wrong_q    <= 1'b0;
            correct_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            progress_q <= progress_d;
            err_cnt_q  <= err_cnt_d;
            key_ack_q  <= key_ack_d;
            wrong_q    <= wrong_d;
            correct_q  <= correct_d;
        end
    end

    assign Correct  = correct_q;
    assign wrong    = wrong_q;
    assign key_ack  = key_ack_q;
    assign progress = progress_q;

endmodule

// File: tb/tb_simon_input_checker.sv
// Scoreboard bench for simon_input_checker: expected accepts are queued as keys
// are driven and compared against the accepts the DUT reports.
module tb_simon_input_checker;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn   = '0;
    logic       clear = 1'b0;
    logic       Correct;
    logic       wrong;
    logic       key_ack;
    logic [3:0] progress;

    int total = 0;
    int bad   = 0;
    int wrong_cnt = 0;
    int viol      = 0;
    int seq_keys[8] = '{1, 5, 0, 7, 2, 6, 3, 4};

    // {Correct, progress} captured on each key_ack, and the expected list
    logic [4:0] ack_q[$];
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    simon_input_checker #(
        .DEBOUNCE_CYCLES(DEB),
        .ERR_HOLD(HOLD),
        .PATTERN(24'o43627051)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
        .clear(clear),
        .Correct(Correct),
        .wrong(wrong),
        .key_ack(key_ack),
        .progress(progress)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
        if (key_ack) ack_q.push_back({Correct, progress});
        if (wrong) wrong_cnt++;
        if ((key_ack && wrong) || (Correct && wrong)) viol++;
    endtask

    task automatic press_key(input int k, input int hold, input int gap);
        btn = 8'(32'd1 << k);
        repeat (hold) cycle();
        btn = '0;
        repeat (gap) cycle();
    endtask

    task automatic enter_keys(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == 7), 4'(i + 1)});
            press_key(seq_keys[i], 10, 10);
        end
    endtask

    task automatic do_clear();
        btn = '0;
        repeat (12) cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
        ack_q.delete();
        exp_q.delete();
        wrong_cnt = 0;
    endtask

    task automatic test_reset();
        #22;
        total++;
        if ({Correct, wrong, key_ack, progress} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b", {Correct, wrong, key_ack, progress}, 7'b0);
        end
        rst_n = 1'b1;
        repeat (5) cycle();
        total++;
        if ({Correct, wrong, key_ack, progress} !== 7'b0) begin
            bad++;
            $display("FAIL after_reset_idle got=%b want=%b", {Correct, wrong, key_ack, progress}, 7'b0);
        end
    endtask

    task automatic test_full_sequence();
        bit ok;
        int drops = 0;
        enter_keys(8);
        total++;
        ok = (ack_q.size() == exp_q.size());
        if (ok) foreach (exp_q[j]) if (ack_q[j] !== exp_q[j]) ok = 0;
        if (!ok) begin
            bad++;
            $display("FAIL full_seq_acks got=%p want=%p", ack_q, exp_q);
        end
        ack_q.delete();
        exp_q.delete();
        total++;
        if (Correct !== 1'b1 || progress !== 4'd8) begin
            bad++;
            $display("FAIL full_seq_done got=%b/%0d want=1/8", Correct, progress);
        end
        for (int n = 0; n < 100; n++) begin
            if (n % 5 == 0) btn = 8'($urandom_range(0, 255));
            cycle();
            if (Correct !== 1'b1 || progress !== 4'd8) drops++;
        end
        btn = '0;
        repeat (12) cycle();
        total++;
        if (drops != 0 || ack_q.size() != 0 || wrong_cnt != 0) begin
            bad++;
            $display("FAIL done_holds got drops=%0d acks=%0d wrong=%0d want 0/0/0",
                     drops, ack_q.size(), wrong_cnt);
        end
        do_clear();
    endtask

    task automatic test_wrong_key();
        bit ok;
        enter_keys(2);
        wrong_cnt = 0;
        press_key(3, 10, 10);
        repeat (10) cycle();
        total++;
        if (wrong_cnt != HOLD || progress !== 4'd0) begin
            bad++;
            $display("FAIL wrong_key got wrong_cycles=%0d progress=%0d want %0d/0",
                     wrong_cnt, progress, HOLD);
        end
        total++;
        ok = (ack_q.size() == exp_q.size());
        if (ok) foreach (exp_q[j]) if (ack_q[j] !== exp_q[j]) ok = 0;
        if (!ok) begin
            bad++;
            $display("FAIL wrong_key_acks got=%p want=%p", ack_q, exp_q);
        end
        ack_q.delete();
        exp_q.delete();
        enter_keys(8);
        total++;
        ok = (ack_q.size() == exp_q.size());
        if (ok) foreach (exp_q[j]) if (ack_q[j] !== exp_q[j]) ok = 0;
        if (!ok || Correct !== 1'b1) begin
            bad++;
            $display("FAIL retry_after_wrong got=%p Correct=%b want=%p Correct=1", ack_q, Correct, exp_q);
        end
        do_clear();
    endtask

    task automatic test_bounce();
        bit ok;
        int ack_at = -1;
        for (int r = 0; r < 6; r++) begin
            btn = 8'h02;
            repeat (3) cycle();
            btn = 8'h00;
            repeat (2) cycle();
        end
        exp_q.push_back({1'b0, 4'd1});
        btn = 8'h02;
        // Cycle 1 closes on the sampling edge; DEB+3 edges later is cycle DEB+4
        for (int n = 1; n <= 10; n++) begin
            cycle();
            if (key_ack && ack_at < 0) ack_at = n;
        end
        btn = '0;
        repeat (10) cycle();
        total++;
        if (ack_at != int'(DEB) + 4) begin
            bad++;
            $display("FAIL bounce_latency got=%0d want=%0d", ack_at, DEB + 4);
        end
        total++;
        ok = (ack_q.size() == exp_q.size());
        if (ok) foreach (exp_q[j]) if (ack_q[j] !== exp_q[j]) ok = 0;
        if (!ok) begin
            bad++;
            $display("FAIL bounce_acks got=%p want=%p", ack_q, exp_q);
        end
        do_clear();
    endtask

    task automatic test_multi_key();
        int max_prog = 0;
        btn = 8'b0000_0011;
        for (int n = 0; n < 30; n++) begin
            if (n == 10) btn = '0;
            cycle();
            if (int'(progress) > max_prog) max_prog = int'(progress);
        end
        total++;
        if (wrong_cnt != HOLD || max_prog != 0 || ack_q.size() != 0) begin
            bad++;
            $display("FAIL multi_key got wrong=%0d maxprog=%0d acks=%0d want %0d/0/0",
                     wrong_cnt, max_prog, ack_q.size(), HOLD);
        end
        do_clear();
    endtask

    task automatic test_error_lockout();
        bit ok;
        btn = 8'h08;
        repeat (8) cycle();
        // Swap directly to key 1 during ERROR and keep holding it
        btn = 8'h02;
        repeat (20) cycle();
        total++;
        if (wrong_cnt != HOLD || ack_q.size() != 0 || progress !== 4'd0) begin
            bad++;
            $display("FAIL error_lockout got wrong=%0d acks=%0d progress=%0d want %0d/0/0",
                     wrong_cnt, ack_q.size(), progress, HOLD);
        end
        btn = '0;
        repeat (12) cycle();
        total++;
        if (ack_q.size() != 0) begin
            bad++;
            $display("FAIL held_release got acks=%0d want 0", ack_q.size());
        end
        exp_q.push_back({1'b0, 4'd1});
        press_key(1, 10, 10);
        total++;
        ok = (ack_q.size() == exp_q.size());
        if (ok) foreach (exp_q[j]) if (ack_q[j] !== exp_q[j]) ok = 0;
        if (!ok) begin
            bad++;
            $display("FAIL repress_after_error got=%p want=%p", ack_q, exp_q);
        end
        do_clear();
    endtask

    task automatic test_clear_and_reset();
        enter_keys(5);
        total++;
        if (progress !== 4'd5) begin
            bad++;
            $display("FAIL pre_clear_progress got=%0d want=5", progress);
        end
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        total++;
        if (progress !== 4'd0) begin
            bad++;
            $display("FAIL clear_progress got=%0d want=0", progress);
        end
        ack_q.delete();
        exp_q.delete();
        enter_keys(8);
        total++;
        if (Correct !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_done got=%b want=1", Correct);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({Correct, wrong, key_ack, progress} !== 7'b0) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b", {Correct, wrong, key_ack, progress}, 7'b0);
        end
        #10;
        rst_n = 1'b1;
        repeat (3) cycle();
        total++;
        if ({Correct, progress} !== 5'b0) begin
            bad++;
            $display("FAIL post_reset_state got=%b want=%b", {Correct, progress}, 5'b0);
        end
        ack_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_wrong_key();
        test_bounce();
        test_multi_key();
        test_error_lockout();
        test_clear_and_reset();
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL exclusive_flags got=%0d want=0", viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simon_input_checker.md
Name: simon_input_checker

Overview:
- User-side counterpart of the Simon LED pattern player.
- Debounces 8 push-buttons and decodes each single-button press into a key index 0..7.
- Checks the key sequence against the same 8-step pattern the player shows.
- Drives `Correct` high once all 8 keys match, which stops the player and lights all LEDs. Runs on the same divided clock as the player.

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles the synchronized button vector must be unchanged before it is accepted as stable; range 1..255.
- `ERR_HOLD`, default 32: cycles that `wrong` stays high after a mismatch; range 1..255.
- `PATTERN`, default 24'o43627051: expected key sequence, entry i at bits [3i+2:3i]. The default sequence is 1,5,0,7,2,6,3,4, i.e. LEDs 2,6,1,8,3,7,4,5.

Ports:
- `clk`, input, 1: divided system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `btn`, input, 8: raw buttons, active-high, asynchronous; bit k is key k.
- `clear`, input, 1: synchronous restart of the check, active-high.
- `Correct`, output, 1: sequence complete and correct; held high.
- `wrong`, output, 1: high for `ERR_HOLD` cycles after a wrong or invalid press.
- `key_ack`, output, 1: one-cycle pulse per accepted correct key.
- `progress`, output, 4: number of correct keys entered so far, 0..8.

Behaviour:
- Interface (already decided): one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: `Correct`=0, `wrong`=0, `key_ack`=0, `progress`=0. The FSM is in IDLE; synchronizer, stable vector and counters are 0.
- Input path:
  - `btn` passes through a 2-flop synchronizer.
  - The debounce counter reloads to 0 whenever the synchronizer output differs from its previous-cycle value; otherwise it increments, saturating.
  - `btn_stable` takes the synchronized value on the cycle the counter reaches `DEBOUNCE_CYCLES`.
  - A constant raw change appears on `btn_stable` exactly `DEBOUNCE_CYCLES`+3 edges after the first edge that samples it. Glitches shorter than `DEBOUNCE_CYCLES` never reach `btn_stable`.
- Press event: one-cycle strobe when `btn_stable` goes from 0 to nonzero.
  - One-hot value: valid key, index = bit position.
  - Multi-hot value: invalid, treated as wrong.
  - Changes between two nonzero values are not new presses.
- FSM states:
  - IDLE: wait for a press event.
    - Valid key equal to `PATTERN[progress]`: pulse `key_ack` and increment `progress`, both on the same edge the FSM leaves IDLE. If the new `progress` is 8, go to DONE, otherwise go to RELEASE.
    - Wrong or invalid key: go to ERROR and load the error counter.
  - RELEASE: wait until `btn_stable`==0, then go to IDLE. Presses are impossible here by definition, since `btn_stable` must pass through 0 first.
  - ERROR: `wrong`=1 and `progress`=0. Count `ERR_HOLD` cycles, then go to RELEASE. Presses are ignored and nothing is queued.
  - DONE: `Correct`=1 and `progress`=8. All presses are ignored. Only `rst_n` or `clear` leaves this state.
- `clear` has priority over all FSM activity. It forces IDLE, clears `progress`/`Correct`/`wrong`/`key_ack` on the next edge, and does not reset the debouncer.
- Buttons held at reset or clear release: `btn_stable` becomes nonzero without a 0→nonzero event, so no press is registered until all buttons are released.
- Reset mid-entry: asserting `rst_n` low immediately zeroes all outputs. No partial progress survives.
- `wrong` and `key_ack` are never high in the same cycle. `wrong` is 0 whenever `Correct` is 1.
- All outputs are registered; there are no combinational paths from `btn` or `clear` to any output.

Test Plan:
All scenarios use `DEBOUNCE_CYCLES`=4, `ERR_HOLD`=8 and the default `PATTERN`.
- Full correct sequence: press and release keys 1,5,0,7,2,6,3,4, each held 10 cycles with 10-cycle gaps.
  - Required: 8 `key_ack` pulses, `progress` steps 1..8.
  - Required: `Correct` rises on the 8th accept and stays high through 100 further cycles of random presses.
- Wrong key: keys 1,5 then 3.
  - Required: `progress` 0→1→2→0; `wrong` is high for exactly 8 cycles.
  - Then after release, keys 1,5,0,7,2,6,3,4 give `Correct`=1.
- Bounce rejection: 3-cycle pulses on key 1, repeated with 2-cycle gaps for 30 cycles, then a steady 10-cycle press.
  - Required: exactly one `key_ack`, occurring `DEBOUNCE_CYCLES`+3=7 edges after the steady level begins, accounting for the final bounce.
- Multi-key press: `btn`=8'b0000_0011 held 10 cycles at `progress`=0.
  - Required: `wrong` pulses for 8 cycles, `progress` stays 0, no `key_ack`.
- Error lockout and hold: during ERROR press key 1. Required: ignored.
  - Next, hold key 1 through the end of ERROR. Required: no `key_ack` until it is released and pressed again.
- Clear and reset: at `progress`=5, pulse `clear` for 1 cycle. Required: `progress`=0 on the next edge.
  - Next, reach DONE, then drive `rst_n` low mid-cycle. Required: `Correct` falls asynchronously; all outputs are 0.
